// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered external RAM port between the
// icache refill engine (read bursts) and the dcache miss/writeback engine.
module ram_port_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         srst_n,
    input  logic                         ic_req,
    input  logic [31:0]                  ic_addr,
    output logic                         ic_gnt,
    output logic                         ic_rvalid,
    output logic [31:0]                  ic_rdata,
    output logic                         ic_done,
    input  logic                         dc_req,
    input  logic                         dc_we,
    input  logic [31:0]                  dc_addr,
    input  logic [31:0]                  dc_wdata,
    output logic [$clog2(BURST_LEN)-1:0] dc_beat,
    output logic                         dc_gnt,
    output logic                         dc_rvalid,
    output logic [31:0]                  dc_rdata,
    output logic                         dc_done,
    output logic [31:0]                  ram_addr,
    output logic [31:0]                  ram_wdata,
    output logic [3:0]                   ram_wen,
    output logic                         ram_ren,
    input  logic [31:0]                  ram_rdata
);

    localparam int              BW        = $clog2(BURST_LEN);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [31:0]     BASE_MASK = ~(32'(BURST_LEN * 4) - 32'd1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BW-1:0]       r_beat;
    logic [BW-1:0]       r_dc_beat;
    logic                r_owner_dc;
    logic                r_last_dc;
    logic                r_ic_gnt;
    logic                r_dc_gnt;
    logic [RD_LAT-1:0]   r_vld_dly;
    logic [RD_LAT-1:0]   r_lst_dly;
    logic [31:0]         r_ram_addr;
    logic [31:0]         r_ram_wdata;
    logic [3:0]          r_ram_wen;
    logic                r_ram_ren;

    logic                w_any_req;
    logic                w_pick_dc;
    logic                w_start_wr;
    logic                w_last_beat;
    logic                w_rd_tail;
    logic                w_start;
    logic                w_step;
    logic                w_issue_end;
    logic                w_lst_in;
    logic                w_wr_done;
    logic [31:0]         w_start_addr;

    // A tie goes to whichever requester was not granted last.
    assign w_any_req    = ic_req | dc_req;
    assign w_pick_dc    = dc_req & (~ic_req | ~r_last_dc);
    assign w_start_wr   = w_pick_dc & dc_we;
    assign w_start_addr = (w_pick_dc ? dc_addr : ic_addr) & BASE_MASK;
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_rd_tail    = r_lst_dly[RD_LAT-1];

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_any_req)   w_state_nxt = w_start_wr ? WR_ISSUE : RD_ISSUE;
            RD_ISSUE: if (w_last_beat) w_state_nxt = RD_DRAIN;
            RD_DRAIN: if (w_rd_tail)   w_state_nxt = IDLE;
            WR_ISSUE: if (w_last_beat) w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_step      = 1'b0;
        w_issue_end = 1'b0;
        w_lst_in    = 1'b0;
        w_wr_done   = 1'b0;
        case (r_state)
            IDLE:     w_start = w_any_req;
            RD_ISSUE: begin
                w_step      = ~w_last_beat;
                w_issue_end = w_last_beat;
                w_lst_in    = w_last_beat;
            end
            WR_ISSUE: begin
                w_step      = ~w_last_beat;
                w_issue_end = w_last_beat;
                w_wr_done   = w_last_beat;
            end
            default: ;
        endcase
    end

    // The delay line mirrors the RAM read latency; owner is stable until IDLE.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            r_beat      <= '0;
            r_dc_beat   <= '0;
            r_owner_dc  <= 1'b0;
            r_last_dc   <= 1'b0;
            r_ic_gnt    <= 1'b0;
            r_dc_gnt    <= 1'b0;
            r_vld_dly   <= '0;
            r_lst_dly   <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_wen   <= '0;
            r_ram_ren   <= 1'b0;
        end else begin
            r_ic_gnt     <= 1'b0;
            r_dc_gnt     <= 1'b0;
            r_vld_dly[0] <= r_ram_ren;
            r_lst_dly[0] <= w_lst_in;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_dly[i] <= r_vld_dly[i-1];
                r_lst_dly[i] <= r_lst_dly[i-1];
            end
            if (w_start) begin
                r_owner_dc <= w_pick_dc;
                r_last_dc  <= w_pick_dc;
                r_ic_gnt   <= ~w_pick_dc;
                r_dc_gnt   <= w_pick_dc;
                r_beat     <= '0;
                r_ram_addr <= w_start_addr;
                r_ram_ren  <= ~w_start_wr;
                r_ram_wen  <= w_start_wr ? 4'hF : 4'h0;
                if (w_start_wr) begin
                    r_ram_wdata <= dc_wdata;
                    r_dc_beat   <= BW'(1);
                end
            end else if (w_step) begin
                r_beat     <= r_beat + BW'(1);
                r_ram_addr <= r_ram_addr + 32'd4;
                if (r_state == WR_ISSUE) begin
                    r_ram_wdata <= dc_wdata;
                    r_dc_beat   <= r_dc_beat + BW'(1);
                end
            end else if (w_issue_end) begin
                r_ram_ren <= 1'b0;
                r_ram_wen <= 4'h0;
                r_dc_beat <= '0;
            end
        end
    end

    assign ic_gnt    = r_ic_gnt;
    assign dc_gnt    = r_dc_gnt;
    assign ic_rvalid = r_vld_dly[RD_LAT-1] & ~r_owner_dc;
    assign dc_rvalid = r_vld_dly[RD_LAT-1] & r_owner_dc;
    assign ic_done   = w_rd_tail & ~r_owner_dc;
    assign dc_done   = (w_rd_tail & r_owner_dc) | w_wr_done;
    assign ic_rdata  = ram_rdata;
    assign dc_rdata  = ram_rdata;
    assign dc_beat   = r_dc_beat;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_wen   = r_ram_wen;
    assign ram_ren   = r_ram_ren;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, cycle-accurate bench for ram_port_arbiter (BURST_LEN=8, RD_LAT=2).
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic        ic_rvalid;
    logic [31:0] ic_rdata;
    logic        ic_done;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic [2:0]  dc_beat;
    logic        dc_gnt;
    logic        dc_rvalid;
    logic [31:0] dc_rdata;
    logic        dc_done;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wen;
    logic        ram_ren;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    // {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, ram_ren, ram_wen}
    logic [10:0] obs;
    logic [10:0] exp_ctl;
    assign obs = {ic_gnt, ic_rvalid, ic_done, dc_gnt, dc_rvalid, dc_done, ram_ren, ram_wen};

    always #5 clk = ~clk;

    ram_port_arbiter #(.BURST_LEN(8), .RD_LAT(2)) dut (
        .clk(clk), .srst_n(srst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_beat(dc_beat), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_done(dc_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_ren(ram_ren),
        .ram_rdata(ram_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        ram_rdata = '0;
        #22;
        checks++;
        if ({obs, ram_addr, ram_wdata, dc_beat} !== '0) begin
            errors++;
            $display("FAIL reset_state got ctl=%b addr=%h wdata=%h beat=%0d exp all zero",
                     obs, ram_addr, ram_wdata, dc_beat);
        end
        @(negedge clk);
        srst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ic_read();
        next_cycle();
        ic_req = 1'b1; ic_addr = 32'h0000_1034;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            ram_rdata = 32'h5A00_0000 + 32'(c);
            if (c == 10) ic_req = 1'b0;
            @(negedge clk);
            exp_ctl = {c == 1, (c >= 3 && c <= 10), c == 10, 3'b000, c <= 8, 4'h0};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL ic_read_ctl c=%0d got %b exp %b", c, obs, exp_ctl);
            end
            if (c <= 8) begin
                checks++;
                if (ram_addr !== 32'h1020 + 32'(4 * (c - 1))) begin
                    errors++;
                    $display("FAIL ic_read_addr c=%0d got %h exp %h", c, ram_addr,
                             32'h1020 + 32'(4 * (c - 1)));
                end
            end
            if (c >= 3 && c <= 10) begin
                checks++;
                if (ic_rdata !== 32'h5A00_0000 + 32'(c)) begin
                    errors++;
                    $display("FAIL ic_read_data c=%0d got %h exp %h", c, ic_rdata,
                             32'h5A00_0000 + 32'(c));
                end
            end
        end
    endtask

    task automatic test_dc_write();
        logic [2:0] exp_beat;
        next_cycle();
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_2000; dc_wdata = 32'hA0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            if (c <= 7) dc_wdata = 32'hA0 + 32'(c);
            if (c == 8) dc_req = 1'b0;
            @(negedge clk);
            exp_ctl  = {3'b000, c == 1, 1'b0, c == 8, 1'b0, (c <= 8) ? 4'hF : 4'h0};
            exp_beat = (c <= 7) ? 3'(c) : 3'd0;
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL dc_write_ctl c=%0d got %b exp %b", c, obs, exp_ctl);
            end
            checks++;
            if (dc_beat !== exp_beat) begin
                errors++;
                $display("FAIL dc_write_beat c=%0d got %0d exp %0d", c, dc_beat, exp_beat);
            end
            if (c <= 8) begin
                checks++;
                if (ram_wdata !== 32'hA0 + 32'(c - 1) ||
                    ram_addr !== 32'h2000 + 32'(4 * (c - 1))) begin
                    errors++;
                    $display("FAIL dc_write_data c=%0d got %h@%h exp %h@%h", c, ram_wdata,
                             ram_addr, 32'hA0 + 32'(c - 1), 32'h2000 + 32'(4 * (c - 1)));
                end
            end
        end
    endtask

    task automatic test_tie_after_reset();
        pulse_reset();
        next_cycle();
        ic_req = 1'b1; ic_addr = 32'h0000_4000;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_3000; dc_wdata = 32'hB0;
        for (int c = 1; c <= 31; c++) begin
            next_cycle();
            ram_rdata = 32'h5A00_0000 + 32'(c);
            if (c == 8)  dc_req = 1'b0;
            if (c == 12) begin dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_5010; end
            if (c == 19) ic_req = 1'b0;
            if (c == 22) dc_req = 1'b0;
            @(negedge clk);
            exp_ctl = {c == 10, (c >= 12 && c <= 19), c == 19,
                       (c == 1 || c == 21), (c >= 23 && c <= 30), (c == 8 || c == 30),
                       ((c >= 10 && c <= 17) || (c >= 21 && c <= 28)),
                       (c <= 8) ? 4'hF : 4'h0};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL tie_ctl c=%0d got %b exp %b", c, obs, exp_ctl);
            end
            if (c == 10 || c == 21) begin
                checks++;
                if (ram_addr !== ((c == 10) ? 32'h4000 : 32'h5000)) begin
                    errors++;
                    $display("FAIL tie_addr c=%0d got %h exp %h", c, ram_addr,
                             (c == 10) ? 32'h4000 : 32'h5000);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        next_cycle();
        ic_req = 1'b1; ic_addr = 32'h0000_8000;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_9000; dc_wdata = 32'h55;
        for (int c = 1; c <= 42; c++) begin
            next_cycle();
            if (c == 32) begin ic_req = 1'b0; dc_req = 1'b0; end
            @(negedge clk);
            exp_ctl = {(c == 10 || c == 30), ((c >= 12 && c <= 19) || (c >= 32 && c <= 39)),
                       (c == 19 || c == 39), (c == 1 || c == 21), 1'b0, (c == 8 || c == 28),
                       ((c >= 10 && c <= 17) || (c >= 30 && c <= 37)),
                       ((c <= 8) || (c >= 21 && c <= 28)) ? 4'hF : 4'h0};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL b2b_ctl c=%0d got %b exp %b", c, obs, exp_ctl);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        next_cycle();
        ic_req = 1'b1; ic_addr = 32'h0000_1034;
        repeat (4) next_cycle();
        @(posedge clk);
        #2;
        srst_n = 1'b0;
        ic_req = 1'b0;
        #1;
        checks++;
        if ({obs, ram_addr, ram_wdata, dc_beat} !== '0) begin
            errors++;
            $display("FAIL midreset_state got ctl=%b addr=%h wdata=%h beat=%0d exp all zero",
                     obs, ram_addr, ram_wdata, dc_beat);
        end
        @(posedge clk);
        @(negedge clk);
        srst_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 11'b0) begin
                errors++;
                $display("FAIL midreset_quiet c=%0d got %b exp 0", c, obs);
            end
        end
        next_cycle();
        ic_req = 1'b1; ic_addr = 32'h0000_6000;
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            if (c == 10) ic_req = 1'b0;
            @(negedge clk);
            exp_ctl = {c == 1, (c >= 3 && c <= 10), c == 10, 3'b000, c <= 8, 4'h0};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL restart_ctl c=%0d got %b exp %b", c, obs, exp_ctl);
            end
            if (c <= 8) begin
                checks++;
                if (ram_addr !== 32'h6000 + 32'(4 * (c - 1))) begin
                    errors++;
                    $display("FAIL restart_addr c=%0d got %h exp %h", c, ram_addr,
                             32'h6000 + 32'(4 * (c - 1)));
                end
            end
        end
    endtask

    task automatic test_drop_req();
        next_cycle();
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_7008;
        for (int c = 1; c <= 11; c++) begin
            next_cycle();
            ram_rdata = 32'h7700_0000 + 32'(c);
            if (c == 3) dc_req = 1'b0;
            @(negedge clk);
            exp_ctl = {3'b000, c == 1, (c >= 3 && c <= 10), c == 10, c <= 8, 4'h0};
            checks++;
            if (obs !== exp_ctl) begin
                errors++;
                $display("FAIL drop_ctl c=%0d got %b exp %b", c, obs, exp_ctl);
            end
            if (c <= 8) begin
                checks++;
                if (ram_addr !== 32'h7000 + 32'(4 * (c - 1))) begin
                    errors++;
                    $display("FAIL drop_addr c=%0d got %h exp %h", c, ram_addr,
                             32'h7000 + 32'(4 * (c - 1)));
                end
            end
            if (c >= 3 && c <= 10) begin
                checks++;
                if (dc_rdata !== 32'h7700_0000 + 32'(c)) begin
                    errors++;
                    $display("FAIL drop_data c=%0d got %h exp %h", c, dc_rdata,
                             32'h7700_0000 + 32'(c));
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ic_read();
        repeat (2) @(posedge clk);
        test_dc_write();
        repeat (2) @(posedge clk);
        test_tie_after_reset();
        repeat (2) @(posedge clk);
        test_back_to_back();
        repeat (2) @(posedge clk);
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        test_drop_req();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Arbitrates the CPU top level's single external 32-bit RAM port (`ram_addr`/`ram_wdata`/`ram_wen`/`ram_ren`/`ram_rdata`) between two requesters: the instruction-cache refill engine (read bursts only) and the data-cache miss/writeback engine (read or write bursts). Each grant runs one aligned burst of `BURST_LEN` word accesses. Requests are served round-robin, and the RAM-side outputs are registered. The block sits between the cache refill logic and the registered external memory boundary of the core.

## Interface
- `BURST_LEN`, 8: words per burst; must be a power of two, ≥2.
- `RD_LAT`, 2: cycles from a `ram_ren` beat on the port to valid `ram_rdata`; must be ≥1.
- `clk` in 1: single clock, rising edge.
- `srst_n` in 1: asynchronous, active-low reset.
- `ic_req` in 1: icache read-burst request; held until `ic_done`.
- `ic_addr` in 32: icache burst byte address.
- `ic_gnt` out 1: one-cycle pulse when the icache burst starts.
- `ic_rvalid` out 1: icache read beat valid.
- `ic_rdata` out 32: icache read beat data.
- `ic_done` out 1: one-cycle pulse on the last icache beat.
- `dc_req` in 1: dcache burst request; held until `dc_done`.
- `dc_we` in 1: dcache burst direction, 1 = write; sampled at grant.
- `dc_addr` in 32: dcache burst byte address.
- `dc_wdata` in 32: write word selected by `dc_beat`.
- `dc_beat` out log2(BURST_LEN): index of the write word the dcache must present.
- `dc_gnt`, `dc_rvalid`, `dc_rdata`, `dc_done`: same meaning as the icache set, for the dcache.
- `ram_addr` out 32: RAM word address (byte address, registered).
- `ram_wdata` out 32: RAM write data (registered).
- `ram_wen` out 4: RAM byte write enables (registered).
- `ram_ren` out 1: RAM read enable (registered).
- `ram_rdata` in 32: RAM read data, valid `RD_LAT` cycles after its `ram_ren` beat.

## Operation
- FSM states:
  - IDLE, RD_ISSUE, RD_DRAIN, WR_ISSUE.
  - IDLE → RD_ISSUE on a granted read.
  - IDLE → WR_ISSUE on a granted dcache write.
  - RD_ISSUE → RD_DRAIN after the last `ram_ren` beat.
  - RD_DRAIN → IDLE after the last rvalid.
  - WR_ISSUE → IDLE after the last write beat.
- Arbitration happens only in IDLE.
  - A lone request wins.
  - If both requesters are asking, the one not granted last wins.
  - The last-grant pointer resets to "icache", so the dcache wins the first tie.
- Base address = `addr & ~(BURST_LEN*4-1)`. Beat k uses `base + 4k`, so a burst never wraps or crosses its aligned block. Low address bits are ignored; there is no critical-word-first ordering.
- Read burst:
  - `ram_ren` = 1 for `BURST_LEN` consecutive cycles, `ram_wen` = 0.
  - An `RD_LAT`-deep shift register of beat-valid bits, tagged with the owner, produces `xx_rvalid`.
  - `xx_rdata` = `ram_rdata` passthrough. `xx_rdata` is don't-care when `xx_rvalid` = 0.
- Write burst:
  - `ram_wen` = 4'hF for `BURST_LEN` cycles, `ram_ren` = 0.
  - At each capturing edge, `ram_wdata` <= `dc_wdata` and `dc_beat` advances.
  - `dc_beat` = 0 in IDLE.
- A requester dropping `req` mid-burst is ignored; the burst completes.
- `ic_req` never produces a write.
- The rvalid/done outputs of the non-owner stay 0 throughout a burst.
- Reset, at any time including mid-burst, immediately forces:
  - state IDLE and the delay line cleared;
  - `ram_ren`=0, `ram_wen`=0, `ram_addr`=0, `ram_wdata`=0;
  - all gnt/rvalid/done outputs = 0, `dc_beat`=0, last-grant = icache.
- Reset mid-burst discards the in-flight burst: no done is produced for it.

## Timing
- Let cycle 0 be an IDLE cycle in which a request is present.
- Cycles 1..`BURST_LEN`: `ram_*` carries beats 0..`BURST_LEN`-1.
- `xx_gnt` is high in cycle 1 only.
- Read:
  - `xx_rvalid` is high in cycles `1+RD_LAT`..`BURST_LEN+RD_LAT`.
  - `xx_done` is high in cycle `BURST_LEN+RD_LAT`, together with the last rvalid.
  - IDLE in cycle `BURST_LEN+RD_LAT+1`.
  - `ram_ren` is 0 from cycle `BURST_LEN+1`.
- Write:
  - The word for beat k is sampled at the end of cycle k (`dc_beat`=k).
  - `dc_done` is high in cycle `BURST_LEN`, with the last write beat on the port.
  - IDLE in cycle `BURST_LEN+1`; `ram_wen` is 0 then.
- Minimum gap between bursts: one IDLE cycle. The next burst's first beat appears in the cycle after that IDLE cycle.
- Peak throughput: `BURST_LEN` words per `BURST_LEN+RD_LAT+1` cycles for reads, per `BURST_LEN+1` cycles for writes.

## Test plan
- Icache read alone: `ic_addr`=0x0000_1034, `BURST_LEN`=8, `RD_LAT`=2.
  - `ram_addr` = 0x1020..0x103C in cycles 1..8.
  - `ic_rvalid` in cycles 3..10.
  - `ic_done` in cycle 10.
  - `dc_*` outputs stay 0.
- Dcache write: `dc_addr`=0x2000, line words 0xA0+k.
  - `ram_wen`=F with `ram_wdata`=0xA0..0xA7 in cycles 1..8.
  - `dc_done` in cycle 8.
  - `ram_ren` never asserted.
- Simultaneous `ic_req` and `dc_req` right after reset:
  - the dcache is granted first;
  - the icache gets `ic_gnt` in the cycle after the IDLE that follows `dc_done`.
  - A third dcache request issued during the icache burst waits for its end.
- Both requesters held continuously for 4 bursts: grants alternate dc, ic, dc, ic, with exactly one IDLE cycle between bursts.
- `srst_n` pulsed low during beat 4 of a read:
  - all outputs are 0 immediately;
  - no `ic_done` is produced;
  - a new request after release starts cleanly from beat 0.
- Requester drops `dc_req` in cycle 3 of a read: the burst still issues 8 beats and pulses `dc_done`.
